// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared definitions for the pipeline control slice: stage-hold
//               codes, jump enable levels, flush FSM state type and a helper
//               that computes the flush counter reload value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    // Stage-hold code bus (Hold_Flag_Bus is 2:0)
    typedef logic [2:0] hold_flag_t;

    localparam hold_flag_t Hold_None = 3'd0;
    localparam hold_flag_t Hold_Pc   = 3'd1;
    localparam hold_flag_t Hold_If   = 3'd2;   // reserved, never generated here
    localparam hold_flag_t Hold_Id   = 3'd3;

    localparam logic JumpEnable  = 1'b1;
    localparam logic JumpDisable = 1'b0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_t;

    // Reload value for the flush counter. The jump cycle itself already holds
    // Hold_Id, so FLUSH only has to cover cycles-1 further decrements.
    function automatic logic [3:0] flush_load(input int cycles);
        if (cycles > 0)
            return 4'(cycles - 1);
        else
            return 4'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Bundle of the pipeline-control request/response signals.
//               master : the pipeline side that raises holds/jumps
//               slave  : pipe_ctrl itself
// Ports       : jump_flag_i/jump_addr_i, hold_ex_i, hold_clint_i, hold_rib_i,
//               timeout_clr_i (into pipe_ctrl); hold_flag_o, jump_flag_o,
//               jump_addr_o, bus_timeout_o, stall_cnt_o, flush_cnt_o (out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic              jump_flag_i;
    logic [31:0]       jump_addr_i;
    logic              hold_ex_i;
    logic              hold_clint_i;
    logic              hold_rib_i;
    logic              timeout_clr_i;
    logic [2:0]        hold_flag_o;
    logic              jump_flag_o;
    logic [31:0]       jump_addr_o;
    logic              bus_timeout_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output jump_flag_i, jump_addr_i, hold_ex_i, hold_clint_i,
               hold_rib_i, timeout_clr_i,
        input  hold_flag_o, jump_flag_o, jump_addr_o, bus_timeout_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  jump_flag_i, jump_addr_i, hold_ex_i, hold_clint_i,
               hold_rib_i, timeout_clr_i,
        output hold_flag_o, jump_flag_o, jump_addr_o, bus_timeout_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/ctrl_wdog.sv
// ============================================================================
// Module      : ctrl_wdog
// Description : Bus-hold watchdog. Counts consecutive cycles of i_hold,
//               saturating at LIMIT, and raises a sticky flag on the edge
//               where the count reaches LIMIT. i_clr clears the flag and wins
//               over a same-cycle set; the counter is not affected by i_clr.
// Ports       : clk, rst (async active-low), i_hold, i_clr, o_flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_wdog #(
    parameter int LIMIT = 1024
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_hold,
    input  wire logic i_clr,
    output logic      o_flag
);

    localparam int W = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] c_LIMIT = W'(LIMIT);
    localparam logic [W-1:0] c_LAST  = W'(LIMIT - 1);

    logic [W-1:0] r_wcnt;
    logic         r_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt <= '0;
            r_flag <= 1'b0;
        end else begin
            if (!i_hold)
                r_wcnt <= '0;
            else if (r_wcnt != c_LIMIT)
                r_wcnt <= r_wcnt + W'(1);

            // ">= c_LAST" covers both the edge that reaches LIMIT and every
            // later edge at saturation, so a cleared flag re-arms while the
            // bus stays held.
            if (i_clr)
                r_flag <= 1'b0;
            else if (i_hold && (r_wcnt >= c_LAST))
                r_flag <= 1'b1;
        end
    end

    assign o_flag = r_flag;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline control unit. Merges EX / interrupt / bus-arbiter
//               hold requests into one stage-hold code, forwards the EX
//               redirect, keeps Hold_Id asserted for FLUSH_CYCLES after a
//               jump, watches for a stuck bus hold and counts stalls/jumps.
// Ports       : clk, rst (async active-low), bus (pipe_ctrl_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int BUS_TIMEOUT  = 1024,
    parameter int CNT_W        = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    pipe_ctrl_if.slave   bus
);

    localparam logic [3:0] c_FLUSH_LOAD = flush_load(FLUSH_CYCLES);

    flush_state_t     r_state;
    logic [3:0]       r_fcnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    hold_flag_t       w_hold;
    logic             w_jump;

    // Outputs are forced quiet while reset is asserted, even though the
    // request inputs are passed through combinationally.
    assign w_jump = rst & bus.jump_flag_i;

    always_comb begin
        w_hold = Hold_None;
        if (rst) begin
            if (bus.jump_flag_i || (r_state == ST_FLUSH) ||
                bus.hold_ex_i || bus.hold_clint_i)
                w_hold = Hold_Id;
            else if (bus.hold_rib_i)
                w_hold = Hold_Pc;
        end
    end

    assign bus.hold_flag_o = w_hold;
    assign bus.jump_flag_o = w_jump;
    assign bus.jump_addr_o = (w_jump == JumpEnable) ? bus.jump_addr_i : 32'h0;

    // Post-jump flush sequencer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_fcnt  <= 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.jump_flag_i && (FLUSH_CYCLES > 0)) begin
                        r_state <= ST_FLUSH;
                        r_fcnt  <= c_FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (bus.jump_flag_i)
                        r_fcnt <= c_FLUSH_LOAD;
                    else if (r_fcnt == 4'd0)
                        r_state <= ST_RUN;
                    else
                        r_fcnt <= r_fcnt - 4'd1;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Performance counters (free-running, wrap naturally)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hold != Hold_None)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (bus.jump_flag_i)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.flush_cnt_o = r_flush_cnt;

    ctrl_wdog #(
        .LIMIT (BUS_TIMEOUT)
    ) u_rib_wdog (
        .clk    (clk),
        .rst    (rst),
        .i_hold (bus.hold_rib_i),
        .i_clr  (bus.timeout_clr_i),
        .o_flag (bus.bus_timeout_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. Directed scenarios plus a
//               randomized run against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam int FC = 1;
    localparam int BT = 4;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_ctrl #(
        .FLUSH_CYCLES (FC),
        .BUS_TIMEOUT  (BT),
        .CNT_W        (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: remaining extra Hold_Id cycles, bus-hold run length,
    // sticky timeout flag, and event counts.
    int            m_rem;
    int            m_run;
    logic          m_flag;
    logic [CW-1:0] m_stall;
    logic [CW-1:0] m_flush;

    task automatic model_reset();
        m_rem = 0; m_run = 0; m_flag = 1'b0; m_stall = '0; m_flush = '0;
    endtask

    function automatic logic [2:0] model_hold();
        if (bus.jump_flag_i || (m_rem > 0) || bus.hold_ex_i || bus.hold_clint_i)
            return 3'd3;
        if (bus.hold_rib_i)
            return 3'd1;
        return 3'd0;
    endfunction

    task automatic set_in(input logic j, input logic [31:0] a, input logic ex,
                          input logic cl, input logic rb, input logic clr);
        bus.jump_flag_i   = j;
        bus.jump_addr_i   = a;
        bus.hold_ex_i     = ex;
        bus.hold_clint_i  = cl;
        bus.hold_rib_i    = rb;
        bus.timeout_clr_i = clr;
        #1;
    endtask

    task automatic tick();
        logic [2:0] h;
        logic j, rb, clr;
        h = model_hold(); j = bus.jump_flag_i; rb = bus.hold_rib_i; clr = bus.timeout_clr_i;
        @(posedge clk);
        if (h != 3'd0) m_stall++;
        if (j) m_flush++;
        m_rem = j ? FC : ((m_rem > 0) ? m_rem - 1 : 0);
        m_run = rb ? m_run + 1 : 0;
        if (clr) m_flag = 1'b0;
        else if (rb && (m_run >= BT)) m_flag = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_in(1, 32'h1234_5678, 1, 1, 1, 0);
        n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_err++; $display("FAIL in_reset_hold: got %0d expected 0", bus.hold_flag_o); end
        n_cmp++; if (bus.jump_flag_o !== 1'b0) begin n_err++; $display("FAIL in_reset_jump: got %0b expected 0", bus.jump_flag_o); end
        n_cmp++; if (bus.jump_addr_o !== 32'h0) begin n_err++; $display("FAIL in_reset_addr: got %0h expected 0", bus.jump_addr_o); end
        set_in(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(0, 0, 0, 0, 0, 0);
            n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_err++; $display("FAIL idle_hold[%0d]: got %0d expected 0", i, bus.hold_flag_o); end
            n_cmp++; if (bus.jump_flag_o !== 1'b0) begin n_err++; $display("FAIL idle_jump[%0d]: got %0b expected 0", i, bus.jump_flag_o); end
            n_cmp++; if (bus.stall_cnt_o !== '0 || bus.flush_cnt_o !== '0) begin n_err++; $display("FAIL idle_cnt[%0d]: got stall=%0d flush=%0d expected 0/0", i, bus.stall_cnt_o, bus.flush_cnt_o); end
            n_cmp++; if (bus.bus_timeout_o !== 1'b0) begin n_err++; $display("FAIL idle_timeout[%0d]: got %0b expected 0", i, bus.bus_timeout_o); end
            tick();
        end
    endtask

    task automatic test_jump();
        set_in(1, 32'h0000_0100, 0, 0, 0, 0);
        n_cmp++; if (bus.jump_flag_o !== 1'b1) begin n_err++; $display("FAIL jump_flag: got %0b expected 1", bus.jump_flag_o); end
        n_cmp++; if (bus.jump_addr_o !== 32'h100) begin n_err++; $display("FAIL jump_addr: got %0h expected 100", bus.jump_addr_o); end
        n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_err++; $display("FAIL jump_hold0: got %0d expected 3", bus.hold_flag_o); end
        tick();
        set_in(0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_err++; $display("FAIL jump_hold1: got %0d expected 3", bus.hold_flag_o); end
        n_cmp++; if (bus.jump_addr_o !== 32'h0) begin n_err++; $display("FAIL jump_addr_idle: got %0h expected 0", bus.jump_addr_o); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_err++; $display("FAIL jump_hold2: got %0d expected 0", bus.hold_flag_o); end
        n_cmp++; if (bus.flush_cnt_o !== 32'd1) begin n_err++; $display("FAIL jump_flush_cnt: got %0d expected 1", bus.flush_cnt_o); end
        n_cmp++; if (bus.stall_cnt_o !== 32'd2) begin n_err++; $display("FAIL jump_stall_cnt: got %0d expected 2", bus.stall_cnt_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] f0;
        logic [3:0] jumps = 4'b0011;
        logic [2:0] exp_h [4] = '{3'd3, 3'd3, 3'd3, 3'd0};
        f0 = m_flush;
        for (int i = 0; i < 4; i++) begin
            set_in(jumps[i], 32'h0000_0200 + 32'(i), 0, 0, 0, 0);
            n_cmp++; if (bus.hold_flag_o !== exp_h[i]) begin n_err++; $display("FAIL b2b_hold[%0d]: got %0d expected %0d", i, bus.hold_flag_o, exp_h[i]); end
            tick();
        end
        n_cmp++; if (bus.flush_cnt_o !== f0 + 32'd2) begin n_err++; $display("FAIL b2b_flush_cnt: got %0d expected %0d", bus.flush_cnt_o, f0 + 32'd2); end
    endtask

    task automatic test_priority();
        set_in(0, 0, 1, 0, 1, 0);
        n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_err++; $display("FAIL prio_ex_rib: got %0d expected 3", bus.hold_flag_o); end
        tick();
        set_in(0, 0, 0, 0, 1, 0);
        n_cmp++; if (bus.hold_flag_o !== 3'd1) begin n_err++; $display("FAIL prio_rib: got %0d expected 1", bus.hold_flag_o); end
        tick();
        set_in(0, 0, 0, 1, 1, 0);
        n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_err++; $display("FAIL prio_clint_rib: got %0d expected 3", bus.hold_flag_o); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_err++; $display("FAIL prio_none: got %0d expected 0", bus.hold_flag_o); end
        tick();
    endtask

    task automatic test_watchdog();
        set_in(0, 0, 0, 0, 0, 0); tick(); tick();
        for (int k = 0; k < 6; k++) begin
            set_in(0, 0, 0, 0, 1, 0);
            n_cmp++; if (bus.bus_timeout_o !== (k >= BT)) begin n_err++; $display("FAIL wdog_rise[%0d]: got %0b expected %0b", k, bus.bus_timeout_o, (k >= BT)); end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.bus_timeout_o !== 1'b1) begin n_err++; $display("FAIL wdog_sticky0: got %0b expected 1", bus.bus_timeout_o); end
        tick();
        n_cmp++; if (bus.bus_timeout_o !== 1'b1) begin n_err++; $display("FAIL wdog_sticky1: got %0b expected 1", bus.bus_timeout_o); end
        set_in(0, 0, 0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.bus_timeout_o !== 1'b0) begin n_err++; $display("FAIL wdog_clear: got %0b expected 0", bus.bus_timeout_o); end
        // Clear held through saturation: clear must win every edge
        for (int k = 0; k < 7; k++) begin
            set_in(0, 0, 0, 0, 1, 1);
            n_cmp++; if (bus.bus_timeout_o !== 1'b0) begin n_err++; $display("FAIL wdog_clr_wins[%0d]: got %0b expected 0", k, bus.bus_timeout_o); end
            tick();
        end
        set_in(0, 0, 0, 0, 1, 0);
        n_cmp++; if (bus.bus_timeout_o !== 1'b0) begin n_err++; $display("FAIL wdog_after_clr: got %0b expected 0", bus.bus_timeout_o); end
        tick();
        n_cmp++; if (bus.bus_timeout_o !== 1'b1) begin n_err++; $display("FAIL wdog_reset_sat: got %0b expected 1", bus.bus_timeout_o); end
        set_in(0, 0, 0, 0, 0, 1); tick();
        set_in(0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_random();
        logic rib = 1'b0;
        logic [2:0] eh;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rib = ~rib;
            set_in(($urandom_range(0, 4) == 0), $urandom, ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 9) == 0), rib, ($urandom_range(0, 19) == 0));
            eh = model_hold();
            n_cmp++; if (bus.hold_flag_o !== eh) begin n_err++; $display("FAIL rnd_hold[%0d]: got %0d expected %0d", i, bus.hold_flag_o, eh); end
            n_cmp++; if (bus.jump_flag_o !== bus.jump_flag_i) begin n_err++; $display("FAIL rnd_jump[%0d]: got %0b expected %0b", i, bus.jump_flag_o, bus.jump_flag_i); end
            n_cmp++; if (bus.jump_addr_o !== (bus.jump_flag_i ? bus.jump_addr_i : 32'h0)) begin n_err++; $display("FAIL rnd_addr[%0d]: got %0h expected %0h", i, bus.jump_addr_o, bus.jump_flag_i ? bus.jump_addr_i : 32'h0); end
            n_cmp++; if (bus.bus_timeout_o !== m_flag) begin n_err++; $display("FAIL rnd_timeout[%0d]: got %0b expected %0b", i, bus.bus_timeout_o, m_flag); end
            n_cmp++; if (bus.stall_cnt_o !== m_stall) begin n_err++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", i, bus.stall_cnt_o, m_stall); end
            n_cmp++; if (bus.flush_cnt_o !== m_flush) begin n_err++; $display("FAIL rnd_flush[%0d]: got %0d expected %0d", i, bus.flush_cnt_o, m_flush); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        set_in(0, 0, 0, 0, 0, 0); tick(); tick();
        set_in(1, 32'h0000_0300, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 1, 0);
        n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_err++; $display("FAIL ar_in_flush: got %0d expected 3", bus.hold_flag_o); end
        #2 rst = 1'b0;
        bus.jump_flag_i = 1'b1;
        #1;
        n_cmp++; if (bus.hold_flag_o !== 3'd0 || bus.jump_flag_o !== 1'b0 || bus.jump_addr_o !== 32'h0) begin n_err++; $display("FAIL ar_outputs: got hold=%0d jump=%0b addr=%0h expected 0/0/0", bus.hold_flag_o, bus.jump_flag_o, bus.jump_addr_o); end
        n_cmp++; if (bus.stall_cnt_o !== '0 || bus.flush_cnt_o !== '0 || bus.bus_timeout_o !== 1'b0) begin n_err++; $display("FAIL ar_regs: got stall=%0d flush=%0d to=%0b expected 0/0/0", bus.stall_cnt_o, bus.flush_cnt_o, bus.bus_timeout_o); end
        bus.jump_flag_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        set_in(0, 0, 0, 0, 1, 0);
        n_cmp++; if (bus.hold_flag_o !== 3'd1) begin n_err++; $display("FAIL ar_run_rib: got %0d expected 1", bus.hold_flag_o); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_err++; $display("FAIL ar_run_idle: got %0d expected 0", bus.hold_flag_o); end
        n_cmp++; if (bus.stall_cnt_o !== m_stall) begin n_err++; $display("FAIL ar_stall: got %0d expected %0d", bus.stall_cnt_o, m_stall); end
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_jump();
        test_back_to_back();
        test_priority();
        test_watchdog();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
